fc_stream_feeder: RTL and testbench
===================================

# fc_stream_feeder

Flattening serializer that sits between the last pooling stage and the fully-connected classifier. It collects one I_SIZE×I_SIZE feature map of CI channels, one pixel (all channels in parallel) at a time. It then streams the flattened vector to the FC layer as one signed word per cycle under a `ce` strobe, in the exact index order the FC weight bank expects. The FC input has no backpressure, so the whole vector is emitted as an unbroken burst.

## Interface
- `I_BW`, 16: width of one signed feature word.
- `I_SIZE`, 4: feature-map side length (pixels per row and rows per map).
- `CI`, 12: number of channels per pixel.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `global_rst_n`  in  1  reset; asynchronous and active-low.
- `rst_processEnd`  in  1  synchronous end-of-image clear; same effect as reset, applied on the clock edge.
- `i_en`  in  1  pixel-valid strobe.
- `i_data`  in  CI*I_BW  one pixel; channel c occupies `i_data[c*I_BW +: I_BW]`, signed.
- `o_data`  out  I_BW  signed flattened word to the FC layer.
- `o_ce`  out  1  word-valid strobe; this drives the FC `ce` input.
- `o_done`  out  1  one-cycle pulse after the final word of a burst.
- `o_busy`  out  1  high in STREAM and DONE.
- `o_overflow`  out  1  sticky flag: a pixel arrived while not in FILL.

## Operation
- Sizes: P = I_SIZE*I_SIZE pixels per map; N = CI*P words per burst (defaults: P = 16, N = 192).
- Storage is a register array of N words.
- Pixel p (0..P-1, arrival order = row*I_SIZE+col) channel c is written to index c*P + p. The order is channel-major, matching the FC weight indexing.
- **FILL**
  - Each `i_en` cycle stores all CI channels of `i_data` at pixel index `pix_cnt`, then increments `pix_cnt`.
  - When a pixel is stored with `pix_cnt` = P-1: `pix_cnt` clears, `rd_cnt` clears, and the state moves to STREAM.
- **STREAM**
  - Every cycle: `o_data` ← mem[`rd_cnt`], `o_ce` ← 1, `rd_cnt` increments.
  - After word N-1 is issued, the state moves to DONE.
- **DONE**
  - Lasts one cycle: `o_done` = 1, `o_ce` = 0; then the state returns to FILL.
- Any `i_en` in STREAM or DONE:
  - the pixel is dropped and storage is unchanged;
  - `o_overflow` is set and stays set until reset or `rst_processEnd`.
- Counter widths: `pix_cnt` is clog2(P)+1 bits; `rd_cnt` is clog2(N)+1 bits. Comparisons use the full counter widths, so the counters never wrap.
- `rst_processEnd` takes priority over `i_en` and over state progress. It clears:
  - the state (to FILL) and both counters;
  - `o_ce`, `o_done`, `o_data`, `o_overflow`.
  - Storage contents need not be cleared; they are fully overwritten before the next burst.
- Reset mid-burst (either reset source) truncates the burst immediately: `o_ce` is low on the next cycle and no `o_done` is produced.

## Timing
- Reset values: `o_data` = 0, `o_ce` = 0, `o_done` = 0, `o_busy` = 0, `o_overflow` = 0; state FILL; counters 0.
- All outputs are registered.
- Latency:
  - `i_en` for the last pixel is sampled at edge T.
  - First `o_ce` = 1 (word 0) is visible after edge T+1.
  - Word k is visible after edge T+1+k.
  - `o_ce` stays high for exactly N consecutive cycles.
  - `o_done` is high in the cycle after the last word; `o_ce` is low in that cycle.
- The block accepts a new pixel at the edge after `o_done` is visible.
- Minimum period between bursts: P + N + 1 cycles.
- Pixels may arrive with arbitrary gaps; FILL has no timeout.
- The FC layer sees `ce` low on the `o_done` cycle, which starts its bias/classification sequence.

## Configuration
- `FC_FEEDER_RELU_EN`
  - Defined: every streamed word is clamped, so a value with sign bit set is emitted as 0. The clamp is applied on the read path only; storage keeps raw values.
  - Undefined: words are emitted unmodified, two's complement.
  - Latency, counts and handshake are identical in both builds.

## Test plan
- Default parameters: feed 16 pixels with channel c of pixel p = c*16+p. Required: 192 consecutive `o_ce` cycles with `o_data` = 0,1,2,…,191; then one `o_done` cycle; `o_busy` high for 193 cycles.
- Pixels spaced with 3 idle cycles between them. Required: the first `o_ce` occurs exactly 1 cycle after the 16th `i_en` edge; the word sequence is identical to the previous test.
- Hold `i_en` high continuously for 220 cycles. Required:
  - the first 16 pixels are streamed;
  - pixels arriving during STREAM and DONE are dropped and `o_overflow` = 1;
  - pixels from the cycle after DONE start a new FILL.
- Assert `rst_processEnd` at burst word 50. Required:
  - `o_ce` = 0 on the following cycle, no `o_done`, `o_overflow` = 0;
  - the next 16 pixels produce a full, correct 192-word burst.
- Assert `global_rst_n` low asynchronously mid-FILL (after 7 pixels). Required: all outputs go to 0 immediately; a fresh 16-pixel fill is needed before any `o_ce`.
- Load channel values -5 (0xFFFB) and +7. Required: with `FC_FEEDER_RELU_EN` the output is 0 and 7; without it the output is 0xFFFB and 7.

Source files
------------

// File: rtl/fc_stream_feeder.sv
// fc_stream_feeder
// Flattening serializer between the last pooling stage and the FC classifier.
// Collects one I_SIZE x I_SIZE map of CI channels (one pixel per i_en), then
// emits the channel-major flattened vector (index c*P + p) as an unbroken
// burst of N = CI*I_SIZE*I_SIZE words under o_ce, followed by a one-cycle
// o_done pulse.
//
// Ports:
//   clk            rising-edge clock
//   global_rst_n   asynchronous active-low reset
//   rst_processEnd synchronous end-of-image clear (same effect as reset)
//   i_en           pixel-valid strobe
//   i_data         one pixel, channel c at i_data[c*I_BW +: I_BW], signed
//   o_data         flattened word to the FC layer (registered)
//   o_ce           word-valid strobe, drives FC ce (registered)
//   o_done         one-cycle pulse after the last word of a burst (registered)
//   o_busy         high while in STREAM or DONE (registered)
//   o_overflow     sticky: a pixel arrived outside FILL (registered)
//
// Build option: define FC_FEEDER_RELU_EN to clamp negative words to zero on
// the read path (storage keeps raw values).

module fc_stream_feeder #(
  parameter int I_BW   = 16,
  parameter int I_SIZE = 4,
  parameter int CI     = 12
) (
  input  logic                 clk,
  input  logic                 global_rst_n,
  input  logic                 rst_processEnd,
  input  logic                 i_en,
  input  logic [CI*I_BW-1:0]   i_data,
  output logic [I_BW-1:0]      o_data,
  output logic                 o_ce,
  output logic                 o_done,
  output logic                 o_busy,
  output logic                 o_overflow
);

  localparam int P  = I_SIZE * I_SIZE;
  localparam int N  = CI * P;
  localparam int PW = $clog2(P) + 1;
  localparam int RW = $clog2(N) + 1;
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [PW-1:0]   pix_cnt_r, pix_next_s;
  logic [RW-1:0]   rd_cnt_r, rd_next_s;
  logic [I_BW-1:0] data_next_s;
  logic            ce_next_s;
  logic            done_next_s;
  logic            busy_next_s;
  logic            ovf_next_s;
  logic            wr_en_s;
  logic [AW-1:0]   wr_idx_s [CI];
  logic [AW-1:0]   rd_idx_s;
  logic [I_BW-1:0] rd_word_s;
  logic [I_BW-1:0] mem_r [N];

  // Read-path shaping: optional clamp of negative words to zero.
  function automatic logic [I_BW-1:0] shape_word(input logic [I_BW-1:0] w);
`ifdef FC_FEEDER_RELU_EN
    if (w[I_BW-1]) begin
      shape_word = {I_BW{1'b0}};
    end else begin
      shape_word = w;
    end
`else
    shape_word = w;
`endif
  endfunction

  // Channel-major write addresses for the current pixel, plus the read address.
  always_comb begin
    for (int c = 0; c < CI; c++) begin
      wr_idx_s[c] = AW'(c * P) + AW'(pix_cnt_r);
    end
    rd_idx_s  = rd_cnt_r[AW-1:0];
    rd_word_s = mem_r[rd_idx_s];
  end

  // Next-state and next-output logic; rst_processEnd overrides everything.
  always_comb begin
    state_next_s = state_r;
    pix_next_s   = pix_cnt_r;
    rd_next_s    = rd_cnt_r;
    data_next_s  = o_data;
    ce_next_s    = 1'b0;
    done_next_s  = 1'b0;
    wr_en_s      = 1'b0;
    ovf_next_s   = o_overflow;

    case (state_r)
      ST_FILL: begin
        if (i_en) begin
          wr_en_s = 1'b1;
          if (pix_cnt_r == PW'(P - 1)) begin
            pix_next_s   = {PW{1'b0}};
            rd_next_s    = {RW{1'b0}};
            state_next_s = ST_STREAM;
          end else begin
            pix_next_s   = pix_cnt_r + PW'(1);
          end
        end else begin
          pix_next_s = pix_cnt_r;
        end
      end
      ST_STREAM: begin
        ce_next_s   = 1'b1;
        data_next_s = shape_word(rd_word_s);
        rd_next_s   = rd_cnt_r + RW'(1);
        if (rd_cnt_r == RW'(N - 1)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      ST_DONE: begin
        done_next_s  = 1'b1;
        state_next_s = ST_FILL;
      end
      default: begin
        state_next_s = ST_FILL;
        pix_next_s   = {PW{1'b0}};
        rd_next_s    = {RW{1'b0}};
      end
    endcase

    if (rst_processEnd) begin
      state_next_s = ST_FILL;
      pix_next_s   = {PW{1'b0}};
      rd_next_s    = {RW{1'b0}};
      data_next_s  = {I_BW{1'b0}};
      ce_next_s    = 1'b0;
      done_next_s  = 1'b0;
      wr_en_s      = 1'b0;
      ovf_next_s   = 1'b0;
    end else begin
      // A pixel outside FILL is dropped; remember that it happened.
      ovf_next_s = o_overflow | (i_en & (state_r != ST_FILL));
    end

    busy_next_s = (state_next_s != ST_FILL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_r    <= ST_FILL;
      pix_cnt_r  <= {PW{1'b0}};
      rd_cnt_r   <= {RW{1'b0}};
      o_data     <= {I_BW{1'b0}};
      o_ce       <= 1'b0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      pix_cnt_r  <= pix_next_s;
      rd_cnt_r   <= rd_next_s;
      o_data     <= data_next_s;
      o_ce       <= ce_next_s;
      o_done     <= done_next_s;
      o_busy     <= busy_next_s;
      o_overflow <= ovf_next_s;
    end
  end

  // Feature storage; not reset because every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int c = 0; c < CI; c++) begin
        mem_r[wr_idx_s[c]] <= i_data[c*I_BW +: I_BW];
      end
    end
  end

endmodule

// File: tb/tb_fc_stream_feeder.sv
// Self-checking bench for fc_stream_feeder: directed sequence with random
// pixel data, checked against a map-level reference (word k of a burst is
// channel k/P of pixel k%P, optionally clamped).

module tb_fc_stream_feeder;

  localparam int I_BW   = 16;
  localparam int I_SIZE = 4;
  localparam int CI     = 12;
  localparam int P      = I_SIZE * I_SIZE;
  localparam int N      = CI * P;

  logic                 clk = 1'b0;
  logic                 global_rst_n;
  logic                 rst_processEnd;
  logic                 i_en;
  logic [CI*I_BW-1:0]   i_data;
  logic [I_BW-1:0]      o_data;
  logic                 o_ce;
  logic                 o_done;
  logic                 o_busy;
  logic                 o_overflow;

  int total = 0;
  int bad   = 0;

  logic [I_BW-1:0] map_m [P][CI];
  logic [I_BW-1:0] map_n [P][CI];

  always #5 clk = ~clk;

  fc_stream_feeder #(.I_BW(I_BW), .I_SIZE(I_SIZE), .CI(CI)) dut (
    .clk(clk),
    .global_rst_n(global_rst_n),
    .rst_processEnd(rst_processEnd),
    .i_en(i_en),
    .i_data(i_data),
    .o_data(o_data),
    .o_ce(o_ce),
    .o_done(o_done),
    .o_busy(o_busy),
    .o_overflow(o_overflow)
  );

  function automatic logic [I_BW-1:0] model_word(input int k);
    logic [I_BW-1:0] v;
    v = map_m[k % P][k / P];
`ifdef FC_FEEDER_RELU_EN
    if (v[I_BW-1]) v = 16'h0000;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input int p);
    for (int c = 0; c < CI; c++) i_data[c*I_BW +: I_BW] = map_m[p][c];
    i_en = 1'b1;
  endtask

  task automatic send_pixel(input int p, input int gap);
    drive_pixel(p);
    step();
    i_en = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_range(input int first, input int last, input int gap);
    for (int p = first; p <= last; p++) send_pixel(p, (p == P - 1) ? 0 : gap);
  endtask

  task automatic rand_map();
    logic [31:0] r;
    for (int p = 0; p < P; p++)
      for (int c = 0; c < CI; c++) begin
        r = $urandom;
        map_m[p][c] = r[I_BW-1:0];
      end
  endtask

  task automatic pattern_map();
    for (int p = 0; p < P; p++)
      for (int c = 0; c < CI; c++) map_m[p][c] = I_BW'(c * P + p);
  endtask

  // Called right after the edge that sampled the last pixel.
  task automatic check_burst(input string tag);
    int bc;
    bc = 0;
    chk({tag, "_ce_pre"}, o_ce, 0);
    if (o_busy === 1'b1) bc++;
    step();
    chk({tag, "_first_ce"}, o_ce, 1);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_data"}, o_data, model_word(k));
      chk({tag, "_ce"}, o_ce, 1);
      chk({tag, "_no_done"}, o_done, 0);
      if (o_busy === 1'b1) bc++;
      step();
    end
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_ce_off"}, o_ce, 0);
    if (o_busy === 1'b1) bc++;
    step();
    chk({tag, "_done_pulse"}, o_done, 0);
    if (o_busy === 1'b1) bc++;
    chk({tag, "_busy_cycles"}, bc, N + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_ce"}, o_ce, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_ovf"}, o_overflow, 0);
  endtask

  initial begin
    logic [31:0] r;
    global_rst_n   = 1'b0;
    rst_processEnd = 1'b0;
    i_en           = 1'b0;
    i_data         = '0;
    repeat (3) step();
    chk_all_zero("reset");
    global_rst_n = 1'b1;
    step();

    // Back-to-back pixels, value = flat index.
    pattern_map();
    send_range(0, P - 1, 0);
    check_burst("seq");

    // Three idle cycles between pixels.
    pattern_map();
    send_range(0, P - 1, 3);
    check_burst("gap3");

    // i_en held high for 220 cycles with random data.
    for (int i = 0; i < 220; i++) begin
      r = $urandom;
      for (int c = 0; c < CI; c++) begin
        r = $urandom;
        i_data[c*I_BW +: I_BW] = r[I_BW-1:0];
        if (i < P) map_m[i][c] = r[I_BW-1:0];
        else if (i >= P + N + 1) map_n[i - (P + N + 1)][c] = r[I_BW-1:0];
      end
      i_en = 1'b1;
      step();
      chk("hold_ce", o_ce, (i >= P && i < P + N) ? 1 : 0);
      if (i >= P && i < P + N) chk("hold_data", o_data, model_word(i - P));
      chk("hold_done", o_done, (i == P + N) ? 1 : 0);
      chk("hold_ovf", o_overflow, (i >= P) ? 1 : 0);
    end
    i_en = 1'b0;
    rand_map();
    for (int p = 0; p < 220 - (P + N + 1); p++)
      for (int c = 0; c < CI; c++) map_m[p][c] = map_n[p][c];
    send_range(220 - (P + N + 1), P - 1, 0);
    check_burst("hold_second");
    chk("ovf_sticky", o_overflow, 1);
    rst_processEnd = 1'b1;
    step();
    rst_processEnd = 1'b0;
    chk("ovf_cleared", o_overflow, 0);

    // rst_processEnd at burst word 50.
    rand_map();
    send_range(0, P - 1, 0);
    repeat (11) step();
    i_en = 1'b1;
    step();
    i_en = 1'b0;
    chk("trunc_ovf_set", o_overflow, 1);
    repeat (39) step();
    chk("trunc_word50", o_data, model_word(50));
    chk("trunc_ce50", o_ce, 1);
    rst_processEnd = 1'b1;
    step();
    rst_processEnd = 1'b0;
    chk_all_zero("trunc");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("trunc_no_done", o_done, 0);
      chk("trunc_no_ce", o_ce, 0);
    end
    rand_map();
    send_range(0, P - 1, 0);
    check_burst("after_trunc");

    // Asynchronous reset mid-FILL after 7 pixels.
    rand_map();
    send_range(0, 6, 0);
    #2;
    global_rst_n = 1'b0;
    #1;
    chk_all_zero("async");
    #1;
    global_rst_n = 1'b1;
    step();
    rand_map();
    send_range(0, 8, 0);
    for (int i = 0; i < 3; i++) begin
      chk("async_no_ce", o_ce, 0);
      step();
    end
    send_range(9, P - 1, 0);
    check_burst("after_async");

    // Sign handling: channel 0 = -5, channel 1 = +7.
    rand_map();
    for (int p = 0; p < P; p++) begin
      map_m[p][0] = 16'hFFFB;
      map_m[p][1] = 16'h0007;
    end
    send_range(0, P - 1, 0);
    check_burst("sign");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
